// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizes, bridge state type and element indexing for the matrix datapath
// Purpose: one place for the matrix geometry so the bridge, serializer and compute engine agree.
// Ports: none (package).
package matrix_pkg;

    localparam int VAR_WIDTH = 4;
    localparam int M_SIZE    = 4;
    localparam int BUS_W     = 8;
    localparam int MAT_W     = VAR_WIDTH * M_SIZE * M_SIZE;
    localparam int NBYTES    = MAT_W / BUS_W;
    localparam int CNT_W     = $clog2(NBYTES);

    typedef enum logic [2:0] {
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_SEND
    } bridge_state_t;

    // Element e lives at bits [VAR_WIDTH*e +: VAR_WIDTH] of a packed matrix.
    function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col);
        return row * M_SIZE + col;
    endfunction

endpackage

// File: rtl/matrix_stream_bridge_if.sv
// rtl/matrix_stream_bridge_if.sv - byte streams and compute-engine signals of the matrix bridge
// Purpose: bundles the input byte stream, output byte stream and the packed compute-engine link.
// Ports (signals): in_data/in_valid/in_ready, out_data/out_valid/out_ready,
//                  matrix_a/matrix_b/mm_start towards the engine, mm_done/result_in from it.
// Modports: slave = the bridge, master = the environment driving it.
interface matrix_stream_bridge_if;
    import matrix_pkg::*;

    logic [BUS_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [BUS_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [MAT_W-1:0] matrix_a;
    logic [MAT_W-1:0] matrix_b;
    logic             mm_start;
    logic             mm_done;
    logic [MAT_W-1:0] result_in;

    modport slave (
        input  in_data, in_valid, out_ready, mm_done, result_in,
        output in_ready, out_data, out_valid, matrix_a, matrix_b, mm_start
    );

    modport master (
        output in_data, in_valid, out_ready, mm_done, result_in,
        input  in_ready, out_data, out_valid, matrix_a, matrix_b, mm_start
    );

endinterface

// File: rtl/matrix_byte_serializer.sv
// rtl/matrix_byte_serializer.sv - streams a captured MAT_W word out as NBYTES bytes, LSB byte first
// Purpose: result path of the bridge; load captures a word and presents byte 0 on the next cycle.
// Ports: clk, rst (async active-low), clear (sync abort, keeps data),
//        load/load_data (parallel capture), out_data/out_valid/out_ready (byte stream),
//        last_byte (current byte is the final one of the word).
module matrix_byte_serializer
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [MAT_W-1:0] load_data,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last_byte
);

    logic [MAT_W-1:0] res_q, res_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             consume;
    logic             at_last;

    assign consume = out_valid_q && out_ready;
    assign at_last = (cnt_q == CNT_W'(NBYTES - 1));

    always_comb begin
        res_d       = res_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (clear) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end else if (load) begin
            res_d       = load_data;
            out_data_d  = load_data[BUS_W-1:0];
            out_valid_d = 1'b1;
            cnt_d       = '0;
        end else if (consume) begin
            // res_q[BUS_W-1:0] is always the byte on out_data, so the next byte is one lane up.
            res_d      = res_q >> BUS_W;
            out_data_d = res_q[2*BUS_W-1:BUS_W];
            if (at_last) begin
                out_valid_d = 1'b0;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            res_q       <= res_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign last_byte = out_valid_q && at_last;

endmodule

// File: rtl/matrix_stream_bridge.sv
// rtl/matrix_stream_bridge.sv - byte-serial front end for the matrix multiply unit
// Purpose: collects 8 bytes of A then 8 bytes of B, pulses mm_start, waits for mm_done,
//          then streams the 64-bit result back as 8 bytes (byte n = bits [8n+7:8n]).
// Ports: clk, rst (async active-low), clear (sync abort to S_LOAD_A, matrices kept),
//        bus (slave modport): input/output byte streams and the packed engine link.
module matrix_stream_bridge
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    matrix_stream_bridge_if.slave  bus
);

    bridge_state_t    state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [MAT_W-1:0] mat_a_q, mat_a_d;
    logic [MAT_W-1:0] mat_b_q, mat_b_d;

    logic             in_ready_c;
    logic             mm_start_c;
    logic             accept;
    logic             last_in;
    logic             ser_load;
    logic             ser_last;
    logic             ser_valid;
    logic [BUS_W-1:0] ser_data;

    assign accept   = bus.in_valid && in_ready_c;
    assign last_in  = (byte_cnt_q == CNT_W'(NBYTES - 1));
    // mm_done only matters while waiting; clear wins over a simultaneous done.
    assign ser_load = (state_q == S_WAIT) && bus.mm_done && !clear;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_LOAD_A;
            byte_cnt_q <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_LOAD_A;
        end else begin
            case (state_q)
                S_LOAD_A: if (accept && last_in)           state_d = S_LOAD_B;
                S_LOAD_B: if (accept && last_in)           state_d = S_START;
                S_START:                                   state_d = S_WAIT;
                S_WAIT:   if (bus.mm_done)                 state_d = S_SEND;
                S_SEND:   if (ser_last && bus.out_ready)   state_d = S_LOAD_A;
                default:                                   state_d = S_LOAD_A;
            endcase
        end
    end

    // Deserializer datapath: byte counter and matrix byte lanes
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        if (!clear && accept) begin
            if (state_q == S_LOAD_A) begin
                mat_a_d[BUS_W * int'(byte_cnt_q) +: BUS_W] = bus.in_data;
            end else begin
                mat_b_d[BUS_W * int'(byte_cnt_q) +: BUS_W] = bus.in_data;
            end
        end
        // Any state change (including the one forced by clear) restarts the count.
        if (clear || (state_d != state_q)) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end
    end

    // Output decode
    always_comb begin
        in_ready_c = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
        mm_start_c = (state_q == S_START);
    end

    matrix_byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (ser_load),
        .load_data (bus.result_in),
        .out_data  (ser_data),
        .out_valid (ser_valid),
        .out_ready (bus.out_ready),
        .last_byte (ser_last)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.mm_start  = mm_start_c;
    assign bus.matrix_a  = mat_a_q;
    assign bus.matrix_b  = mat_b_q;
    assign bus.out_data  = ser_data;
    assign bus.out_valid = ser_valid;

endmodule

// File: tb/tb_matrix_stream_bridge.sv
// tb/tb_matrix_stream_bridge.sv - directed self-checking bench for matrix_stream_bridge
module tb_matrix_stream_bridge;
    import matrix_pkg::*;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    matrix_stream_bridge_if bus ();

    matrix_stream_bridge dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load_mat(input logic [63:0] v);
        for (int i = 0; i < 8; i++) send_byte(v[8*i +: 8]);
    endtask

    // Called right after the 16th accept; engine answers 5 cycles after mm_start.
    task automatic compute(input logic [63:0] res);
        check("mm_start_high", 64'(bus.mm_start), 64'd1);
        tick();
        check("mm_start_low", 64'(bus.mm_start), 64'd0);
        repeat (3) tick();
        check("no_early_valid", 64'(bus.out_valid), 64'd0);
        bus.result_in = res;
        bus.mm_done   = 1'b1;
        tick();
        bus.mm_done   = 1'b0;
    endtask

    task automatic recv(input logic [63:0] exp, input int stall_idx, input int nbytes);
        int idx    = 0;
        int stalls = 0;
        int guard  = 0;
        while (idx < nbytes && guard < 100) begin
            guard++;
            if (bus.out_valid) begin
                check($sformatf("out_byte%0d", idx), 64'(bus.out_data), 64'(exp[8*idx +: 8]));
                if (idx == stall_idx && stalls < 3) begin
                    bus.out_ready = 1'b0;
                    stalls++;
                end else begin
                    bus.out_ready = 1'b1;
                    idx++;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            tick();
        end
        bus.out_ready = 1'b0;
        check("recv_count", 64'(idx), 64'(nbytes));
    endtask

    task automatic after_send();
        int extra = 0;
        check("done_out_valid", 64'(bus.out_valid), 64'd0);
        check("done_in_ready", 64'(bus.in_ready), 64'd1);
        check("done_state", 64'(dut.state_q), 64'(S_LOAD_A));
        bus.out_ready = 1'b1;
        repeat (4) begin
            if (bus.out_valid) extra++;
            tick();
        end
        bus.out_ready = 1'b0;
        check("extra_bytes", 64'(extra), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    localparam logic [63:0] A1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] R1 = 64'h0123456789ABCDEF;

    initial begin
        logic [63:0] b4, a5, b5_part, exp_b;
        int unsigned e;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mm_done   = 1'b0;
        bus.result_in = '0;

        // Reset state
        repeat (2) tick();
        check("rst_state", 64'(dut.state_q), 64'(S_LOAD_A));
        check("rst_byte_cnt", 64'(dut.byte_cnt_q), 64'd0);
        check("rst_matrix_a", bus.matrix_a, 64'd0);
        check("rst_matrix_b", bus.matrix_b, 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_mm_start", 64'(bus.mm_start), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b1;
        tick();

        // 1. Load A
        load_mat(A1);
        check("t1_matrix_a", bus.matrix_a, A1);
        check("t1_state", 64'(dut.state_q), 64'(S_LOAD_B));
        check("t1_in_ready", 64'(bus.in_ready), 64'd1);
        check("t1_mm_start", 64'(bus.mm_start), 64'd0);
        e = elem_idx(1, 2);
        check("t1_elem_r1c2", 64'(bus.matrix_a[4*e +: 4]), 64'h6);

        // 2. Full transaction
        load_mat(64'h1111111111111111);
        check("t2_matrix_b", bus.matrix_b, 64'h1111111111111111);
        compute(R1);
        recv(R1, -1, 8);
        after_send();
        check("t2_matrix_a_stable", bus.matrix_a, A1);

        // 3. Output backpressure on byte 2 (AB)
        load_mat(A1);
        load_mat(64'h0F1E2D3C4B5A6978);
        compute(R1);
        recv(R1, 2, 8);
        after_send();

        // 4. Input bubbles and a stray mm_done during S_LOAD_B
        b4 = 64'hA5C3E1F00F1E3C5A;
        load_mat(64'h8877665544332211);
        for (int i = 0; i < 8; i++) begin
            send_byte(b4[8*i +: 8]);
            if (i == 3) begin
                bus.in_data = 8'hFF;
                bus.mm_done = 1'b1;
                tick();
                bus.mm_done = 1'b0;
                check("t4_cnt_bubble1", 64'(dut.byte_cnt_q), 64'd4);
                tick();
                check("t4_cnt_bubble2", 64'(dut.byte_cnt_q), 64'd4);
                check("t4_stray_done", 64'(bus.out_valid), 64'd0);
                check("t4_state", 64'(dut.state_q), 64'(S_LOAD_B));
            end
        end
        check("t4_matrix_b", bus.matrix_b, b4);
        compute(64'hDEADBEEFCAFEF00D);
        recv(64'hDEADBEEFCAFEF00D, -1, 8);
        after_send();

        // 5. Clear after 3 B bytes, with a competing valid byte in the same cycle
        a5      = 64'h0011223344556677;
        b5_part = 64'h0000000000C0FFEE;
        exp_b   = {b4[63:24], b5_part[23:0]};
        load_mat(a5);
        for (int i = 0; i < 3; i++) send_byte(b5_part[8*i +: 8]);
        clear        = 1'b1;
        bus.in_data  = 8'hEE;
        bus.in_valid = 1'b1;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_state", 64'(dut.state_q), 64'(S_LOAD_A));
        check("t5_byte_cnt", 64'(dut.byte_cnt_q), 64'd0);
        check("t5_matrix_a", bus.matrix_a, a5);
        check("t5_matrix_b", bus.matrix_b, exp_b);
        load_mat(64'h1234567890ABCDEF);
        load_mat(64'h0202020202020202);
        check("t5_fresh_a", bus.matrix_a, 64'h1234567890ABCDEF);
        check("t5_fresh_b", bus.matrix_b, 64'h0202020202020202);
        compute(64'h76543210FEDCBA98);
        recv(64'h76543210FEDCBA98, -1, 8);
        after_send();

        // 6. Asynchronous reset while byte 4 is on the output
        load_mat(A1);
        load_mat(64'h3333333333333333);
        compute(64'h1122334455667788);
        recv(64'h1122334455667788, -1, 4);
        check("t6_pre_valid", 64'(bus.out_valid), 64'd1);
        check("t6_pre_byte4", 64'(bus.out_data), 64'h44);
        #2;
        rst = 1'b0;
        #1;
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_out_data", 64'(bus.out_data), 64'd0);
        check("t6_matrix_a", bus.matrix_a, 64'd0);
        check("t6_matrix_b", bus.matrix_b, 64'd0);
        check("t6_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_mm_start", 64'(bus.mm_start), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        load_mat(64'h0F0F0F0F0F0F0F0F);
        load_mat(64'hF0F0F0F0F0F0F0F0);
        compute(64'hCAFEBABE01020304);
        recv(64'hCAFEBABE01020304, -1, 8);
        after_send();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
